// File: rtl/piso_frame_scheduler.sv
// piso_frame_scheduler
//
// Shares one PISO shift register between NUM_REQ requesters. Requesters are
// served round-robin, one word per frame. Each frame is a single LOAD cycle,
// then DATA_W shift cycles that can be stalled by pause, then GAP_CYCLES idle
// cycles before the next grant.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-high reset
//   req_valid        per-requester word available
//   req_data         requester i word at [i*DATA_W +: DATA_W]
//   pause            stalls shifting (SHIFT state only)
//   req_ready        one-hot accept pulse (combinational, IDLE only)
//   piso_load        PISO parallel load strobe
//   piso_enable      PISO shift strobe
//   piso_parallel_in word presented to the PISO, held until the next grant
//   bit_valid        PISO serial_out carries a frame bit this cycle
//   active_src       requester owning the current/last frame
//   busy             scheduler is not idle
//   frame_done       pulse on the last shift cycle of a frame
module piso_frame_scheduler #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      pause,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      piso_load,
  output logic                      piso_enable,
  output logic [DATA_W-1:0]         piso_parallel_in,
  output logic                      bit_valid,
  output logic [SRC_W-1:0]          active_src,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SRC_W-1:0] LAST_REQ = SRC_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [SRC_W-1:0] last_grant;

  logic             grant_found;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;
  logic             shift_go;

  // Round-robin search starting just after the previous grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((32'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Accept pulse is gated by reset so nothing is accepted while held in reset.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !reset && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Shift strobes follow pause in the same cycle so a stall takes effect
  // immediately; they are decoded from the state register only.
  assign shift_go    = (state == S_SHIFT) && !pause;
  assign piso_enable = shift_go;
  assign bit_valid   = shift_go;
  assign frame_done  = shift_go && (bit_cnt == BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      bit_cnt          <= '0;
      gap_cnt          <= '0;
      last_grant       <= LAST_REQ;
      piso_load        <= 1'b0;
      piso_parallel_in <= '0;
      active_src       <= '0;
      busy             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            state            <= S_LOAD;
            piso_parallel_in <= req_data[32'(grant_idx)*DATA_W +: DATA_W];
            active_src       <= grant_idx;
            last_grant       <= grant_idx;
            piso_load        <= 1'b1;
            busy             <= 1'b1;
          end
        end
        S_LOAD: begin
          state     <= S_SHIFT;
          piso_load <= 1'b0;
          bit_cnt   <= '0;
        end
        S_SHIFT: begin
          if (shift_go) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              gap_cnt <= '0;
              if (GAP_CYCLES > 0) begin
                state <= S_GAP;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_frame_scheduler.sv
// tb_piso_frame_scheduler
//
// Instance a: GAP_CYCLES=1, checked every cycle against a behavioural model
// (remaining-bit / gap countdowns plus a grant scoreboard) and a bench PISO
// that rebuilds each serial frame. Instance b: GAP_CYCLES=0, back-to-back.
module tb_piso_frame_scheduler;

  localparam int N   = 2;
  localparam int W   = 8;
  localparam int GAP = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic           pause     = 1'b0;
  logic [N-1:0]   req_ready;
  logic           piso_load, piso_enable, bit_valid, busy, frame_done;
  logic [W-1:0]   piso_parallel_in;
  logic [0:0]     active_src;

  logic [N-1:0]   b_req_valid = '0;
  logic [N*W-1:0] b_req_data  = '0;
  logic           b_pause     = 1'b0;
  logic [N-1:0]   b_req_ready;
  logic           b_piso_load, b_piso_enable, b_bit_valid, b_busy, b_frame_done;
  logic [W-1:0]   b_piso_parallel_in;
  logic [0:0]     b_active_src;

  piso_frame_scheduler #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(GAP)) dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .pause(pause), .req_ready(req_ready), .piso_load(piso_load),
    .piso_enable(piso_enable), .piso_parallel_in(piso_parallel_in),
    .bit_valid(bit_valid), .active_src(active_src), .busy(busy),
    .frame_done(frame_done)
  );

  piso_frame_scheduler #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .req_valid(b_req_valid), .req_data(b_req_data),
    .pause(b_pause), .req_ready(b_req_ready), .piso_load(b_piso_load),
    .piso_enable(b_piso_enable), .piso_parallel_in(b_piso_parallel_in),
    .bit_valid(b_bit_valid), .active_src(b_active_src), .busy(b_busy),
    .frame_done(b_frame_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model + per-cycle compare (instance a) ----------------
  int         m_last = N - 1;
  bit         m_load = 1'b0;
  int         m_bits = 0;
  int         m_gap  = 0;
  logic [7:0] m_word = '0;
  int         m_src  = 0;
  logic [7:0] exp_words[$];
  logic [7:0] piso_q   = '0;
  logic [7:0] col_word = '0;
  int         col_cnt  = 0;
  logic [7:0] fw_q[$];

  always @(negedge clock) begin : compare_p
    logic [1:0] e_ready;
    logic       e_en;
    bit         idle;
    int         g;
    if (reset) begin
      m_last = N - 1; m_load = 1'b0; m_bits = 0; m_gap = 0; m_word = '0; m_src = 0;
      exp_words.delete();
      piso_q = '0; col_word = '0; col_cnt = 0;
      chk("rst_ready", req_ready, 0);
      chk("rst_load", piso_load, 0);
      chk("rst_enable", piso_enable, 0);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_parallel_in", piso_parallel_in, 0);
      chk("rst_active_src", active_src, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
    end else begin
      idle = !m_load && (m_bits == 0) && (m_gap == 0);
      g = -1;
      if (idle) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      e_ready = (g >= 0) ? (2'b01 << g) : 2'b00;
      e_en    = !m_load && (m_bits > 0) && !pause;
      chk("req_ready", req_ready, e_ready);
      chk("piso_load", piso_load, m_load);
      chk("piso_enable", piso_enable, e_en);
      chk("bit_valid", bit_valid, e_en);
      chk("parallel_in", piso_parallel_in, m_word);
      chk("active_src", active_src, m_src);
      chk("busy", busy, !idle);
      chk("frame_done", frame_done, e_en && (m_bits == 1));
      if (piso_load && piso_enable) chk("load_enable_overlap", 1, 0);
      // Rebuild the serial frame through a bench PISO (MSB first).
      if (bit_valid) begin
        col_word = {col_word[6:0], piso_q[7]};
        col_cnt++;
      end
      if (frame_done) begin
        chk("frame_bits", col_cnt, W);
        chk("frame_expected", exp_words.size() > 0, 1);
        if (exp_words.size() > 0) chk("frame_word", col_word, exp_words.pop_front());
        fw_q.push_back(col_word);
        col_cnt = 0;
      end
      if (piso_load) piso_q = piso_parallel_in;
      else if (piso_enable) piso_q = {piso_q[6:0], 1'b0};
      // Advance the model by one cycle.
      if (g >= 0) begin
        m_load = 1'b1; m_word = req_data[g*W +: W]; m_src = g; m_last = g;
        exp_words.push_back(m_word);
      end else if (m_load) begin
        m_load = 1'b0; m_bits = W;
      end else if (m_bits > 0) begin
        if (!pause) begin
          m_bits--;
          if (m_bits == 0) m_gap = GAP;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end
    end
  end

  // ---------------- event monitors ----------------
  int         gq_cyc[$], gq_idx[$], ld_cyc[$], dn_cyc[$], idle_cyc[$];
  logic [7:0] ld_par[$];
  int         bv_cnt = 0;
  bit         prev_busy = 1'b0;
  int         bg_cyc[$], bg_idx[$], bdn_cyc[$];
  logic [7:0] bld_par[$];

  always @(negedge clock) begin
    if (req_ready != 0) begin gq_cyc.push_back(cyc); gq_idx.push_back(req_ready[1] ? 1 : 0); end
    if (piso_load) begin ld_cyc.push_back(cyc); ld_par.push_back(piso_parallel_in); end
    if (frame_done) dn_cyc.push_back(cyc);
    if (bit_valid) bv_cnt++;
    if (prev_busy && !busy) idle_cyc.push_back(cyc);
    prev_busy = busy;
    if (b_req_ready != 0) begin bg_cyc.push_back(cyc); bg_idx.push_back(b_req_ready[1] ? 1 : 0); end
    if (b_piso_load) bld_par.push_back(b_piso_parallel_in);
    if (b_frame_done) bdn_cyc.push_back(cyc);
  end

  task automatic clear_mon();
    gq_cyc.delete(); gq_idx.delete(); ld_cyc.delete(); dn_cyc.delete();
    idle_cyc.delete(); ld_par.delete(); fw_q.delete(); bv_cnt = 0;
    bg_cyc.delete(); bg_idx.delete(); bdn_cyc.delete(); bld_par.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_grants(input string name, input int n, input int budget);
    int t;
    t = 0;
    while (gq_cyc.size() < n && t < budget) begin
      step(1);
      t++;
    end
    chk(name, gq_cyc.size() >= n, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t0;
    // 1: reset held with both requesting, then first grant goes to req0.
    reset = 1'b1; req_valid = 2'b11; req_data = {8'h22, 8'h11};
    step(3);
    chk("t1_ready_in_reset", req_ready, 0);
    chk("t1_busy_in_reset", busy, 0);
    clear_mon();
    reset = 1'b0;
    wait_grants("t1_grant_wait", 1, 10);
    req_valid = '0;
    chk("t1_first_grant", gq_idx[0], 0);
    step(14);

    // 2: single frame latency.
    clear_mon();
    req_data[7:0] = 8'hB8; req_valid = 2'b01;
    wait_grants("t2_grant_wait", 1, 20);
    req_valid = '0;
    step(14);
    t0 = gq_cyc[0];
    chk("t2_grant_idx", gq_idx[0], 0);
    chk("t2_load_cycle", ld_cyc[0] - t0, 1);
    chk("t2_load_word", ld_par[0], 8'hB8);
    chk("t2_done_count", dn_cyc.size(), 1);
    chk("t2_done_cycle", dn_cyc[0] - t0, 9);
    chk("t2_idle_cycle", idle_cyc[0] - t0, 11);
    chk("t2_bit_count", bv_cnt, 8);
    chk("t2_serial_word", fw_q[0], 8'hB8);

    // 3: two persistent requesters alternate, 11-cycle frame spacing.
    reset = 1'b1; step(1); reset = 1'b0;
    clear_mon();
    req_data = {8'h60, 8'h7D}; req_valid = 2'b11;
    wait_grants("t3_grant_wait", 4, 60);
    req_valid = '0;
    step(14);
    chk("t3_g0", gq_idx[0], 0);
    chk("t3_g1", gq_idx[1], 1);
    chk("t3_g2", gq_idx[2], 0);
    chk("t3_g3", gq_idx[3], 1);
    for (int k = 0; k < 3; k++) chk("t3_spacing", gq_cyc[k+1] - gq_cyc[k], 11);
    chk("t3_serial0", fw_q[0], 8'h7D);
    chk("t3_serial1", fw_q[1], 8'h60);
    chk("t3_serial2", fw_q[2], 8'h7D);
    chk("t3_serial3", fw_q[3], 8'h60);

    // 4: 3-cycle pause after the 4th shift stretches the frame by 3.
    clear_mon();
    req_data[7:0] = 8'hD8; req_valid = 2'b01;
    wait_grants("t4_grant_wait", 1, 20);
    req_valid = '0;
    step(5);
    pause = 1'b1;
    step(3);
    pause = 1'b0;
    step(10);
    t0 = gq_cyc[0];
    chk("t4_done_cycle", dn_cyc[0] - t0, 12);
    chk("t4_idle_cycle", idle_cyc[0] - t0, 14);
    chk("t4_bit_count", bv_cnt, 8);
    chk("t4_serial_word", fw_q[0], 8'hD8);

    // 5: reset at shift bit 4 aborts the frame; req0 then wins over req1.
    clear_mon();
    req_data = {8'h3C, 8'h5A}; req_valid = 2'b01;
    wait_grants("t5_grant_wait", 1, 20);
    req_valid = '0;
    step(5);
    reset = 1'b1;
    #1;
    chk("t5_enable_now", piso_enable, 0);
    chk("t5_bit_valid_now", bit_valid, 0);
    chk("t5_busy_now", busy, 0);
    chk("t5_parallel_in_now", piso_parallel_in, 0);
    chk("t5_done_now", frame_done, 0);
    step(1);
    reset = 1'b0; req_valid = 2'b11;
    wait_grants("t5_regrant_wait", 2, 20);
    req_valid = 2'b10;
    wait_grants("t5_req1_wait", 3, 30);
    req_valid = '0;
    step(14);
    chk("t5_after_reset_winner", gq_idx[1], 0);
    chk("t5_req1_served", gq_idx[2], 1);
    chk("t5_done_count", dn_cyc.size(), 2);
    chk("t5_bit_count", bv_cnt, 20);
    chk("t5_serial0", fw_q[0], 8'h5A);
    chk("t5_serial1", fw_q[1], 8'h3C);

    // 6: GAP_CYCLES=0, continuous req1 -> 10-cycle back-to-back frames.
    clear_mon();
    b_req_data = {8'hDD, 8'h00}; b_req_valid = 2'b10;
    t = 0;
    while (bg_cyc.size() < 3 && t < 50) begin
      step(1);
      t++;
    end
    chk("t6_grant_wait", bg_cyc.size() >= 3, 1);
    b_req_valid = '0;
    step(12);
    chk("t6_g0", bg_idx[0], 1);
    chk("t6_spacing0", bg_cyc[1] - bg_cyc[0], 10);
    chk("t6_spacing1", bg_cyc[2] - bg_cyc[1], 10);
    chk("t6_done_cycle", bdn_cyc[0] - bg_cyc[0], 9);
    chk("t6_ready_after_done", bg_cyc[1] - bdn_cyc[0], 1);
    chk("t6_load_word", bld_par[0], 8'hDD);
    chk("t6_done_count", bdn_cyc.size(), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
